// File: rtl/mvm_layer_ctrl.sv
// Sequencing FSM for one fully-connected layer: loads the x vector, walks G row
// groups of weight/x reads with MAC enables, then drains each group's results.
module mvm_layer_ctrl #(
    parameter int M = 8,
    parameter int N = 4,
    parameter int P = 2,
    localparam int G  = (M + P - 1) / P,
    localparam int XW = (N > 1) ? $clog2(N) : 1,
    localparam int WW = (G * N > 1) ? $clog2(G * N) : 1,
    localparam int OW = (P > 1) ? $clog2(P) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          x_wr_en_o,
    output logic [XW-1:0] x_addr_o,
    output logic [WW-1:0] w_addr_o,
    output logic          acc_clr_o,
    output logic          acc_en_o,
    output logic [OW-1:0] out_sel_o
);
    localparam int KW = $clog2(N + 1);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    localparam logic [XW-1:0] LD_LAST = XW'(N - 1);
    localparam logic [KW-1:0] K_END   = KW'(N);
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [GW-1:0] G_LAST  = GW'(G - 1);
    localparam logic [OW-1:0] O_FULL  = OW'(P - 1);
    localparam logic [OW-1:0] O_TAIL  = OW'(M - (G - 1) * P - 1);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] ld_q, ld_d;
    logic [KW-1:0] k_q, k_d;
    logic [GW-1:0] g_q, g_d;
    logic [OW-1:0] o_q, o_d;
    logic [OW-1:0] o_last;

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        k_d     = k_q;
        g_d     = g_q;
        o_d     = o_q;
        // the last group may be short when P does not divide M
        o_last  = (g_q == G_LAST) ? O_TAIL : O_FULL;
        case (state_q)
            LOAD: begin
                if (s_valid_i) begin
                    if (ld_q == LD_LAST) begin
                        ld_d    = '0;
                        g_d     = '0;
                        k_d     = '0;
                        state_d = COMPUTE;
                    end else begin
                        ld_d = ld_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (k_q == K_END) begin
                    k_d     = '0;
                    o_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (m_ready_i) begin
                    if (o_q == o_last) begin
                        o_d = '0;
                        if (g_q != G_LAST) begin
                            g_d     = g_q + 1'b1;
                            k_d     = '0;
                            state_d = COMPUTE;
                        end else begin
                            g_d     = '0;
                            state_d = LOAD;
                        end
                    end else begin
                        o_d = o_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                ld_d    = '0;
                k_d     = '0;
                g_d     = '0;
                o_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= LOAD;
            ld_q    <= '0;
            k_q     <= '0;
            g_q     <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            k_q     <= k_d;
            g_q     <= g_d;
            o_q     <= o_d;
        end
    end

    // Reads issued at k land one cycle later, so the MACs run on k = 1..N.
    always_comb begin
        s_ready_o = 1'b0;
        m_valid_o = 1'b0;
        x_wr_en_o = 1'b0;
        x_addr_o  = '0;
        w_addr_o  = '0;
        acc_clr_o = 1'b0;
        acc_en_o  = 1'b0;
        out_sel_o = '0;
        if (!reset_i) begin
            case (state_q)
                LOAD: begin
                    s_ready_o = 1'b1;
                    x_wr_en_o = s_valid_i;
                    x_addr_o  = ld_q;
                end
                COMPUTE: begin
                    if (k_q != K_END) begin
                        x_addr_o = k_q[XW-1:0];
                        w_addr_o = WW'(int'(g_q) * N + int'(k_q));
                    end
                    acc_en_o  = (k_q != '0);
                    acc_clr_o = (k_q == K_ONE);
                end
                DRAIN: begin
                    m_valid_o = 1'b1;
                    out_sel_o = o_q;
                end
                default: begin
                    s_ready_o = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/mvm_layer_ctrl.md
# mvm_layer_ctrl

Control FSM for one fully-connected layer of a `network_*` datapath (matrix-vector multiply y = W·x, P parallel MACs). It accepts the N-element input vector over a valid/ready stream and writes it into the x memory. It then sequences weight/x addresses and accumulator enables for ceil(M/P) row groups. Finally it streams each group's P results out over a valid/ready stream. It holds no data: data paths, memories, MACs and ReLU live in the datapath it drives.

## Interface
- `M`, 8, output vector length (rows of W)
- `N`, 4, input vector length (columns of W)
- `P`, 2, parallel MAC units; 1 ≤ P ≤ M
- `G` (localparam), ceil(M/P), row groups
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `s_valid`  in  1  input element valid (upstream)
- `s_ready`  out  1  controller accepts input element
- `m_valid`  out  1  output element valid (downstream)
- `m_ready`  in  1  downstream accepts output element
- `x_wr_en`  out  1  write current `data_in` into x memory at `x_addr`
- `x_addr`  out  $clog2(N) (min 1)  x memory address
- `w_addr`  out  $clog2(G*N) (min 1)  weight ROM address, shared by all P banks
- `acc_clr`  out  1  MACs load product instead of accumulating
- `acc_en`  out  1  MACs update this cycle
- `out_sel`  out  $clog2(P) (min 1)  selects which MAC result drives `data_out`

## Operation
- States: LOAD, COMPUTE, DRAIN. Counters: `ld` (0..N-1), `k` (0..N), `g` (0..G-1), `o` (0..P-1).
- Reset: state=LOAD, all counters 0, all outputs 0 while `reset`=1.
- LOAD: `s_ready`=1, `x_addr`=`ld`, `x_wr_en`=`s_valid`. Each handshake increments `ld`. The handshake at `ld`=N-1 clears `ld`, sets `g`=0, `k`=0 and enters COMPUTE.
- COMPUTE (memories have 1-cycle synchronous read):
  - While `k`<N: issue `x_addr`=`k`, `w_addr`=g·N+`k`.
  - `acc_en`=1 when `k`≥1. `acc_clr`=1 only when `k`=1.
  - `k` increments every cycle. At `k`=N, after the last `acc_en`, clear `k`, set `o`=0 and enter DRAIN.
  - COMPUTE lasts exactly N+1 cycles.
- DRAIN: `m_valid`=1, `out_sel`=`o`, `acc_en`=0 (MAC results hold).
  - Each handshake increments `o`.
  - Group size is R = P, except the last group (g=G-1), where R = M-(G-1)·P.
  - The handshake at `o`=R-1 goes to COMPUTE with `g`+1 if `g`<G-1. Otherwise it goes to LOAD with `g`=0.
- `s_ready`=0 outside LOAD; `m_valid`=0 outside DRAIN; `x_wr_en`, `acc_en`, `acc_clr` are 0 in any state not listed above.
- The x memory is not overwritten until all G groups are drained, so no input is accepted during COMPUTE or DRAIN.

## Timing
- `s_ready`, `m_valid`, addresses and enables are combinational from registered state/counters only. Neither ready nor valid depends combinationally on the opposite-side input.
- Input handshake = `s_valid`&&`s_ready` at posedge; output handshake = `m_valid`&&`m_ready` at posedge.
- `s_valid` low in LOAD: stall, `ld` holds, `x_wr_en`=0.
- `m_ready` low in DRAIN: `m_valid` stays 1 and `out_sel` holds until accepted.
- Minimum cycles per vector with `s_valid`=`m_ready`=1: N + G·(N+1) + M. Defaults: 4+20+8 = 32.
- First `m_valid` occurs N+1 cycles after the last input handshake.
- `reset` at any cycle, including mid-COMPUTE or mid-DRAIN: the next cycle is LOAD with counters 0. Partially loaded or partially drained vectors are discarded; no stray `acc_en` or `m_valid`.
- Degenerate cases:
  - N=1: COMPUTE is 2 cycles, with `acc_clr` and `acc_en` together in cycle 2.
  - P=M: G=1, single group.

## Test plan
- Defaults, `s_valid`=`m_ready`=1:
  - 4 writes at `x_addr` 0..3.
  - Then per group g: `w_addr` g·4+0..3 in consecutive cycles, `acc_en` on cycles 2..5 of COMPUTE, `acc_clr` on cycle 2 only.
  - Then `out_sel` 0,1.
  - 8 outputs total; next `s_ready` at cycle 32.
- M=7, P=2: 4 groups, last DRAIN emits 1 output (`out_sel`=0), then LOAD. 7 output handshakes per vector.
- Random `s_valid`/`m_ready` (50%), 100 vectors, against a cycle model:
  - exactly N writes per vector, with addresses in order.
  - exactly M outputs per vector.
  - `m_valid`/`out_sel` stable under `m_ready`=0.
- `reset` pulsed at COMPUTE `k`=2, then again after 1 DRAIN handshake: the following cycle shows `s_ready`=1, `x_addr`=0, `acc_en`=0, `m_valid`=0. Then the next vector runs a clean full sequence.
- Integrated: instantiate with datapath as layer 1 of the network (N=4, M=8) and run 2500 random vectors with random handshakes. Streamed `data_out` matches the golden expected file, 0 errors.
- N=1, P=M=3: per vector, 1 write, 2-cycle COMPUTE (`acc_clr`&`acc_en` in cycle 2), 3 outputs `out_sel` 0,1,2.
